// File: rtl/ext_mem_pkg.sv
// Shared types and constant helpers for the external memory bridge.
package ext_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_e;

  // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Largest of four timing parameters, used to size the shared phase counter.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for the asynchronous ready/busy pin.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Resets to "busy" so nothing is assumed ready until the pin has been sampled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ext_mem_bridge.sv
// Avalon-MM slave that serialises each bus word into LANES narrow cycles on an
// asynchronous external memory (8-bit flash or 16-bit SRAM) through a tristate pad.
module ext_mem_bridge
  import ext_mem_pkg::*;
#(
  parameter int ADDR_W     = 21,
  parameter int BUS_W      = 32,
  parameter int MEM_W      = 8,
  parameter int SETUP_CYC  = 1,
  parameter int READ_WAIT  = 5,
  parameter int WRITE_WAIT = 5,
  parameter int HOLD_CYC   = 1,
  parameter int USE_READY  = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [ADDR_W-1:0]                    avs_address,
  input  logic                                 avs_read,
  input  logic                                 avs_write,
  input  logic [BUS_W-1:0]                     avs_writedata,
  input  logic [BUS_W/8-1:0]                   avs_byteenable,
  output logic [BUS_W-1:0]                     avs_readdata,
  output logic                                 avs_waitrequest,
  output logic [ADDR_W+clog2(BUS_W/MEM_W)-1:0] mem_addr,
  output logic [MEM_W-1:0]                     mem_dq_out,
  output logic                                 mem_dq_oe,
  input  logic [MEM_W-1:0]                     mem_dq_in,
  output logic                                 mem_ce_n,
  output logic                                 mem_oe_n,
  output logic                                 mem_we_n,
  input  logic                                 mem_ready
);

  localparam int LANES     = BUS_W / MEM_W;
  localparam int LANE_BITS = clog2(LANES);
  localparam int LANE_W    = (LANE_BITS > 0) ? LANE_BITS : 1;
  localparam int MADDR_W   = ADDR_W + LANE_BITS;
  localparam int BPL       = MEM_W / 8;
  localparam int PH_MAX    = max4(SETUP_CYC, READ_WAIT, WRITE_WAIT, HOLD_CYC);
  localparam int PH_W      = (clog2(PH_MAX + 1) > 0) ? clog2(PH_MAX + 1) : 1;

  // Terminal counts are "cycles - 1"; zero-length phases never use theirs.
  localparam logic [PH_W-1:0] SETUP_LAST = PH_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [PH_W-1:0] READ_LAST  = PH_W'(READ_WAIT - 1);
  localparam logic [PH_W-1:0] WRITE_LAST = PH_W'(WRITE_WAIT - 1);
  localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  state_e               state_q, state_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [PH_W-1:0]      phaseCnt_q, phaseCnt_d;
  logic                 isRead_q, isRead_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BUS_W-1:0]     wdata_q, wdata_d;
  logic [LANES-1:0]     laneMask_q, laneMask_d;
  logic [BUS_W-1:0]     rdBuf_q, rdBuf_d;

  logic [BUS_W-1:0]     readData_q;
  logic                 waitReq_q;
  logic                 ceN_q, oeN_q, weN_q, dqOe_q;
  logic [MADDR_W-1:0]   memAddr_q;
  logic [MEM_W-1:0]     dqOut_q;

  logic                 readySync;
  logic [LANES-1:0]     reqMask;
  logic [LANE_W-1:0]    firstLane, nextLane;
  logic                 haveFirst, haveNext;
  logic                 laneEnd;
  logic [PH_W-1:0]      strobeLast;
  logic                 laneState_d;
  logic [MADDR_W-1:0]   memAddrNext;

  // Ready/busy is only synchronised when the board actually wires it up.
  generate
    if (USE_READY != 0) begin : g_ready
      sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (mem_ready),
        .q_o   (readySync)
      );
    end else begin : g_no_ready
      logic unusedReady;
      assign unusedReady = mem_ready;
      assign readySync   = 1'b1;
    end
  endgenerate

  // Work out which lanes a new request touches and where the walk goes next.
  always_comb begin
    reqMask = '0;
    for (int i = 0; i < LANES; i++) begin
      reqMask[i] = avs_read | (|avs_byteenable[i*BPL +: BPL]);
    end
    firstLane = '0;
    haveFirst = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (reqMask[i]) begin
        firstLane = LANE_W'(i);
        haveFirst = 1'b1;
      end
    end
    nextLane = lane_q;
    haveNext = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (laneMask_q[i] && (i > int'(lane_q))) begin
        nextLane = LANE_W'(i);
        haveNext = 1'b1;
      end
    end
  end

  // Transaction FSM: per lane SETUP -> STROBE -> HOLD, then next lane or DONE.
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    phaseCnt_d = phaseCnt_q;
    isRead_d   = isRead_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    laneMask_d = laneMask_q;
    rdBuf_d    = rdBuf_q;
    laneEnd    = 1'b0;
    strobeLast = isRead_q ? READ_LAST : WRITE_LAST;

    case (state_q)
      IDLE: begin
        if (avs_read || avs_write) begin
          isRead_d   = avs_read;
          addr_d     = avs_address;
          wdata_d    = avs_writedata;
          laneMask_d = reqMask;
          lane_d     = firstLane;
          phaseCnt_d = '0;
          if (!haveFirst) begin
            state_d = DONE;
          end else begin
            state_d = (SETUP_CYC > 0) ? SETUP : STROBE;
          end
        end
      end
      SETUP: begin
        if (phaseCnt_q == SETUP_LAST) begin
          phaseCnt_d = '0;
          state_d    = STROBE;
        end else begin
          phaseCnt_d = phaseCnt_q + PH_W'(1);
        end
      end
      STROBE: begin
        // The minimum count saturates and then waits on ready independently.
        if (phaseCnt_q >= strobeLast) begin
          if (readySync) begin
            if (isRead_q) begin
              rdBuf_d[int'(lane_q)*MEM_W +: MEM_W] = mem_dq_in;
            end
            phaseCnt_d = '0;
            if (HOLD_CYC > 0) begin
              state_d = HOLD;
            end else begin
              laneEnd = 1'b1;
            end
          end
        end else begin
          phaseCnt_d = phaseCnt_q + PH_W'(1);
        end
      end
      HOLD: begin
        if (phaseCnt_q == HOLD_LAST) begin
          phaseCnt_d = '0;
          laneEnd    = 1'b1;
        end else begin
          phaseCnt_d = phaseCnt_q + PH_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (laneEnd) begin
      if (haveNext) begin
        lane_d  = nextLane;
        state_d = (SETUP_CYC > 0) ? SETUP : STROBE;
      end else begin
        state_d = DONE;
      end
    end
  end

  assign laneState_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
  assign memAddrNext = (MADDR_W'(addr_d) << LANE_BITS) | MADDR_W'(lane_d);

  // State and latched transaction context.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      phaseCnt_q <= '0;
      isRead_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      laneMask_q <= '0;
      rdBuf_q    <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      phaseCnt_q <= phaseCnt_d;
      isRead_q   <= isRead_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      laneMask_q <= laneMask_d;
      rdBuf_q    <= rdBuf_d;
    end
  end

  // Pad and bus outputs are registered from the next state so they line up
  // exactly with the state they belong to and never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readData_q <= '0;
      waitReq_q  <= 1'b1;
      ceN_q      <= 1'b1;
      oeN_q      <= 1'b1;
      weN_q      <= 1'b1;
      dqOe_q     <= 1'b0;
      memAddr_q  <= '0;
      dqOut_q    <= '0;
    end else begin
      waitReq_q <= (state_d != DONE);
      ceN_q     <= !laneState_d;
      oeN_q     <= !((state_d == STROBE) && isRead_d);
      weN_q     <= !((state_d == STROBE) && !isRead_d);
      dqOe_q    <= laneState_d && !isRead_d;
      if (laneState_d) begin
        memAddr_q <= memAddrNext;
        dqOut_q   <= wdata_d[int'(lane_d)*MEM_W +: MEM_W];
      end
      if ((state_d == DONE) && isRead_d) begin
        readData_q <= rdBuf_d;
      end
    end
  end

  assign avs_readdata    = readData_q;
  assign avs_waitrequest = waitReq_q;
  assign mem_addr        = memAddr_q;
  assign mem_dq_out      = dqOut_q;
  assign mem_dq_oe       = dqOe_q;
  assign mem_ce_n        = ceN_q;
  assign mem_oe_n        = oeN_q;
  assign mem_we_n        = weN_q;

endmodule

// File: tb/tb_ext_mem_bridge.sv
// Bench for ext_mem_bridge: an 8-bit flash instance with default timing and a
// 16-bit SRAM instance with no setup/hold, each backed by a small memory model.
module tb_ext_mem_bridge;

  typedef struct {
    logic [31:0] rdata;
    int          latency;
    int          start;
  } expT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cycle = 0;
  int   testsRun = 0;
  int   testsFailed = 0;

  // Port A: defaults (8-bit lanes, setup 1, strobe 5, hold 1, ready used)
  logic [20:0] aAddress = '0;
  logic        aRead = 1'b0, aWrite = 1'b0;
  logic [31:0] aWdata = '0;
  logic [3:0]  aBe = '0;
  logic [31:0] aRdata;
  logic        aWait;
  logic [22:0] aMemAddr;
  logic [7:0]  aDqOut, aDqIn;
  logic        aDqOe, aCeN, aOeN, aWeN;
  logic        aReady = 1'b1;

  // Port B: 16-bit lanes, no setup/hold, ready unused
  logic [20:0] bAddress = '0;
  logic        bRead = 1'b0, bWrite = 1'b0;
  logic [31:0] bWdata = '0;
  logic [3:0]  bBe = '0;
  logic [31:0] bRdata;
  logic        bWait;
  logic [21:0] bMemAddr;
  logic [15:0] bDqOut, bDqIn;
  logic        bDqOe, bCeN, bOeN, bWeN;
  logic        bReady = 1'b1;

  logic [7:0]  memA [0:255];
  logic [15:0] memB [0:255];

  expT         sbA[$];
  expT         sbB[$];

  int          aOeLen, aCeCycles, aDqOeCycles, aDqOeNoCe;
  int          aOeRuns[$];
  logic [22:0] aOeAddrs[$];
  logic [22:0] aWeAddrs[$];
  logic [7:0]  aWeData[$];
  logic        aWePrev = 1'b1;
  int          bCeCycles, bCeRuns, bOeLo, bOeHi;
  logic        bCePrev = 1'b1;

  always #5 clk = ~clk;

  assign aDqIn = memA[aMemAddr[7:0]];
  assign bDqIn = memB[bMemAddr[7:0]];

  ext_mem_bridge dutA (
    .clk(clk), .reset(reset),
    .avs_address(aAddress), .avs_read(aRead), .avs_write(aWrite),
    .avs_writedata(aWdata), .avs_byteenable(aBe),
    .avs_readdata(aRdata), .avs_waitrequest(aWait),
    .mem_addr(aMemAddr), .mem_dq_out(aDqOut), .mem_dq_oe(aDqOe), .mem_dq_in(aDqIn),
    .mem_ce_n(aCeN), .mem_oe_n(aOeN), .mem_we_n(aWeN), .mem_ready(aReady)
  );

  ext_mem_bridge #(.MEM_W(16), .SETUP_CYC(0), .HOLD_CYC(0), .USE_READY(0)) dutB (
    .clk(clk), .reset(reset),
    .avs_address(bAddress), .avs_read(bRead), .avs_write(bWrite),
    .avs_writedata(bWdata), .avs_byteenable(bBe),
    .avs_readdata(bRdata), .avs_waitrequest(bWait),
    .mem_addr(bMemAddr), .mem_dq_out(bDqOut), .mem_dq_oe(bDqOe), .mem_dq_in(bDqIn),
    .mem_ce_n(bCeN), .mem_oe_n(bOeN), .mem_we_n(bWeN), .mem_ready(bReady)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearLogs();
    aOeLen = 0; aCeCycles = 0; aDqOeCycles = 0; aDqOeNoCe = 0;
    aOeRuns.delete(); aOeAddrs.delete(); aWeAddrs.delete(); aWeData.delete();
    bCeCycles = 0; bCeRuns = 0; bOeLo = 0; bOeHi = 0;
  endtask

  // Drive one request and push what it must produce onto that port's scoreboard.
  task automatic applyStimulus(input bit port, input bit rd, input bit wr, input logic [20:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input logic [31:0] expRdata, input int expLatency);
    expT e;
    @(posedge clk); #1;
    clearLogs();
    e.rdata = expRdata;
    e.latency = expLatency;
    e.start = cycle;
    if (port == 1'b0) begin
      sbA.push_back(e);
      aAddress = addr; aRead = rd; aWrite = wr; aWdata = wdata; aBe = be;
    end else begin
      sbB.push_back(e);
      bAddress = addr; bRead = rd; bWrite = wr; bWdata = wdata; bBe = be;
    end
  endtask

  // Hold the request until accepted, then drop it; waitrequest must rise again.
  task automatic waitDone(input bit port);
    int n;
    logic w;
    n = 0;
    do begin
      @(negedge clk);
      w = port ? bWait : aWait;
      n++;
    end while (w && n < 500);
    checkOutput(port ? "doneSeenB" : "doneSeenA", w, 1'b0);
    @(posedge clk); #1;
    if (port == 1'b0) begin aRead = 1'b0; aWrite = 1'b0; end
    else begin bRead = 1'b0; bWrite = 1'b0; end
    @(negedge clk);
    w = port ? bWait : aWait;
    checkOutput(port ? "waitHighAfterB" : "waitHighAfterA", w, 1'b1);
  endtask

  initial forever begin
    @(posedge clk);
    cycle = cycle + 1;
  end

  // Completion monitors: pop the scoreboard and compare latency and read data.
  initial forever begin
    expT e;
    @(negedge clk);
    if (!reset && !aWait) begin
      checkOutput("sbHasEntryA", sbA.size() > 0, 1'b1);
      if (sbA.size() > 0) begin
        e = sbA.pop_front();
        checkOutput("latencyA", cycle - e.start, e.latency);
        checkOutput("readdataA", aRdata, e.rdata);
      end
    end
  end

  initial forever begin
    expT e;
    @(negedge clk);
    if (!reset && !bWait) begin
      checkOutput("sbHasEntryB", sbB.size() > 0, 1'b1);
      if (sbB.size() > 0) begin
        e = sbB.pop_front();
        checkOutput("latencyB", cycle - e.start, e.latency);
        checkOutput("readdataB", bRdata, e.rdata);
      end
    end
  end

  // Pad activity logging plus the memory models' write behaviour.
  initial forever begin
    @(negedge clk);
    if (!aCeN) aCeCycles++;
    if (aDqOe) aDqOeCycles++;
    if (aDqOe && aCeN) aDqOeNoCe++;
    if (!aOeN) begin
      if (aOeLen == 0) aOeAddrs.push_back(aMemAddr);
      aOeLen++;
    end else if (aOeLen != 0) begin
      aOeRuns.push_back(aOeLen);
      aOeLen = 0;
    end
    if (!aWeN && aWePrev) begin
      aWeAddrs.push_back(aMemAddr);
      aWeData.push_back(aDqOut);
    end
    if (!aWeN) memA[aMemAddr[7:0]] = aDqOut;
    aWePrev = aWeN;
    if (!bCeN) begin
      bCeCycles++;
      if (bCePrev) bCeRuns++;
    end
    bCePrev = bCeN;
    if (!bOeN && bMemAddr == 22'h0A) bOeLo++;
    if (!bOeN && bMemAddr == 22'h0B) bOeHi++;
    if (!bWeN) memB[bMemAddr[7:0]] = bDqOut;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int c0;
    for (int i = 0; i < 256; i++) begin
      memA[i] = 8'h00;
      memB[i] = 16'h0000;
    end
    memA[8'h40] = 8'h11; memA[8'h41] = 8'h22; memA[8'h42] = 8'h33; memA[8'h43] = 8'h44;
    memB[8'h0A] = 16'hBEEF; memB[8'h0B] = 16'hCAFE;
    clearLogs();

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstWait", aWait, 1'b1);
    checkOutput("rstRdata", aRdata, 32'h0);
    checkOutput("rstCeN", aCeN, 1'b1);
    checkOutput("rstOeN", aOeN, 1'b1);
    checkOutput("rstWeN", aWeN, 1'b1);
    checkOutput("rstDqOe", aDqOe, 1'b0);
    checkOutput("rstMemAddr", aMemAddr, 23'h0);
    checkOutput("rstDqOut", aDqOut, 8'h0);
    reset = 1'b0;
    repeat (3) @(posedge clk);

    // Read word 0x10: bytes 0x40..0x43, 4 lanes x (1+5+1) + 1 = 29 cycles.
    applyStimulus(0, 1, 0, 21'h10, 32'h0, 4'h0, 32'h44332211, 29);
    waitDone(0);
    checkOutput("rdOeRuns", aOeRuns.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < aOeRuns.size()) checkOutput("rdOeLen", aOeRuns[i], 5);
      if (i < aOeAddrs.size()) checkOutput("rdOeAddr", aOeAddrs[i], 23'h40 + 23'(i));
    end
    checkOutput("rdNoWe", aWeAddrs.size(), 0);

    // Sparse write: lanes 0 and 2 only, 1 + 2 x 7 = 15 cycles; readdata holds.
    applyStimulus(0, 0, 1, 21'h3, 32'hA1B2C3D4, 4'b0101, 32'h44332211, 15);
    waitDone(0);
    checkOutput("wrPulses", aWeAddrs.size(), 2);
    if (aWeAddrs.size() == 2) begin
      checkOutput("wrAddr0", aWeAddrs[0], 23'h0C);
      checkOutput("wrData0", aWeData[0], 8'hD4);
      checkOutput("wrAddr1", aWeAddrs[1], 23'h0E);
      checkOutput("wrData1", aWeData[1], 8'hB2);
    end
    checkOutput("wrDqOeCycles", aDqOeCycles, 14);
    checkOutput("wrDqOeOutsideCe", aDqOeNoCe, 0);
    checkOutput("wrNoOe", aOeRuns.size(), 0);

    // No byte enabled: straight to DONE, no chip-enable activity.
    applyStimulus(0, 0, 1, 21'h7, 32'hFFFFFFFF, 4'b0000, 32'h44332211, 1);
    waitDone(0);
    checkOutput("be0CeCycles", aCeCycles, 0);
    checkOutput("be0NoWe", aWeAddrs.size(), 0);

    // Read and write together: the read wins.
    applyStimulus(0, 1, 1, 21'h10, 32'h55555555, 4'hF, 32'h44332211, 29);
    waitDone(0);
    checkOutput("prioNoWe", aWeAddrs.size(), 0);

    // Full write then read back through the memory model.
    applyStimulus(0, 0, 1, 21'h20, 32'hDEADBEEF, 4'hF, 32'h44332211, 29);
    waitDone(0);
    checkOutput("fullWrPulses", aWeAddrs.size(), 4);
    applyStimulus(0, 1, 0, 21'h20, 32'h0, 4'h0, 32'hDEADBEEF, 29);
    waitDone(0);

    // Ready low into the first strobe; raised during strobe cycle 15, seen by
    // the synchroniser two cycles later, so lane 0 strobes 17 = 5+10+2 cycles.
    // Lane 0 then takes 1+17+1 = 19, total 1 + 19 + 3 x 7 = 41.
    aReady = 1'b0;
    repeat (3) @(posedge clk);
    applyStimulus(0, 1, 0, 21'h10, 32'h0, 4'h0, 32'h44332211, 41);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (aOeN && n < 100);
    checkOutput("rdyOeStarted", aOeN, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    aReady = 1'b1;
    waitDone(0);
    checkOutput("rdyOeRuns", aOeRuns.size(), 4);
    if (aOeRuns.size() == 4) begin
      checkOutput("rdyOeLen0", aOeRuns[0], 17);
      checkOutput("rdyOeLen1", aOeRuns[1], 5);
      checkOutput("rdyOeLen3", aOeRuns[3], 5);
    end

    // Reset at cycle 8 of a read, then a clean read afterwards.
    applyStimulus(0, 1, 0, 21'h10, 32'h0, 4'h0, 32'h44332211, 29);
    c0 = cycle;
    while (cycle < c0 + 8) @(negedge clk);
    checkOutput("midCeActive", aCeN, 1'b0);
    reset = 1'b1;
    #1;
    checkOutput("midRstCeN", aCeN, 1'b1);
    checkOutput("midRstOeN", aOeN, 1'b1);
    checkOutput("midRstWait", aWait, 1'b1);
    checkOutput("midRstRdata", aRdata, 32'h0);
    sbA.delete();
    aRead = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    applyStimulus(0, 1, 0, 21'h10, 32'h0, 4'h0, 32'h44332211, 29);
    waitDone(0);

    // 16-bit SRAM: word 5 -> halfwords 0x0A, 0x0B; 2 lanes x 5 + 1 = 11.
    applyStimulus(1, 1, 0, 21'h5, 32'h0, 4'h0, 32'hCAFEBEEF, 11);
    waitDone(1);
    checkOutput("b16CeRuns", bCeRuns, 1);
    checkOutput("b16CeCycles", bCeCycles, 10);
    checkOutput("b16OeLane0", bOeLo, 5);
    checkOutput("b16OeLane1", bOeHi, 5);

    checkOutput("sbDrainedA", sbA.size(), 0);
    checkOutput("sbDrainedB", sbB.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
